// File: rtl/serial_sub_pkg.sv
// Shared widths and FSM state encoding for the serial subtractor.
// No logic; imported by the slice and the top.
package serial_sub_pkg;
  localparam int W     = 16;
  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sub4.sv
// One 4-bit subtract slice: d = a - b - bi, bo set when the slice underflows.
// Latency: combinational; backpressure: none.
module sub4
  import serial_sub_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bi,
  output logic [SLICE-1:0] d,
  output logic             bo
);
  logic [SLICE:0] r;

  // The extra top bit goes high exactly when the slice result is negative.
  always_comb r = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bi};

  assign d  = r[SLICE-1:0];
  assign bo = r[SLICE];
endmodule

// File: rtl/serial_sub16.sv
// Serial subtractor: D = A - B - bin, one SLICE-bit slice per cycle through a single sub4.
// Latency: done pulses W/SLICE+1 cycles after accept; backpressure: ready low while computing.
module serial_sub16 #(
  parameter int W     = serial_sub_pkg::W,
  parameter int SLICE = serial_sub_pkg::SLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         bin,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] D,
  output logic         bout,
  output logic         ovf
);
  import serial_sub_pkg::*;

  localparam int NSL   = W / SLICE;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  state_t             state, state_nx;
  logic [W-1:0]       a_q, b_q;
  logic [W-SLICE-1:0] acc_q;
  logic               brw_q;
  logic [IDX_W-1:0]   idx_q;

  logic [SLICE-1:0]   sl_a, sl_b, sl_d;
  logic               sl_bo;
  logic               last, accept;

  assign sl_a   = a_q[idx_q*SLICE +: SLICE];
  assign sl_b   = b_q[idx_q*SLICE +: SLICE];
  assign last   = (idx_q == IDX_W'(NSL - 1));
  assign accept = start && ready;

  sub4 u_sub4 (
    .a  (sl_a),
    .b  (sl_b),
    .bi (brw_q),
    .d  (sl_d),
    .bo (sl_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: begin
        ready = 1'b0;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? CALC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Finished slices shift down through acc_q so the last slice lands the full word on D at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      brw_q <= 1'b0;
      idx_q <= '0;
      D     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      brw_q <= bin;
      idx_q <= '0;
    end else if (state == CALC) begin
      brw_q <= sl_bo;
      acc_q <= {sl_d, acc_q[W-SLICE-1:SLICE]};
      if (last) begin
        idx_q <= '0;
        D     <= {sl_d, acc_q};
        bout  <= sl_bo;
        ovf   <= (a_q[W-1] ^ b_q[W-1]) & (sl_d[SLICE-1] ^ a_q[W-1]);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_serial_sub16.sv
// Scoreboard bench for serial_sub16: expected results queued at accept, checked on done.
module tb_serial_sub16;
  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [15:0] A, B;
  logic        ready, done, bout, ovf;
  logic [15:0] D;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t q[$];

  serial_sub16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .D     (D),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic bi, input int acc);
    exp_t       m;
    logic [16:0] r;
    r     = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    m.d   = r[15:0];
    m.bo  = r[16];
    m.ov  = (a[15] != b[15]) && (r[15] != a[15]);
    m.acc = acc;
    return m;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("D", D, e.d);
        chk("bout", bout, e.bo);
        chk("ovf", ovf, e.ov);
        chk("latency", cyc - e.acc, 32'd4);
        chk("ready_in_done", ready, 1'b1);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1'b1);
  endtask

  // Accepts one op, queues its expected result, then scrambles the inputs.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi);
    wait_ready();
    start = 1'b1;
    A = a; B = b; bin = bi;
    @(posedge clk);
    #1;
    q.push_back(model(a, b, bi, cyc));
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); bin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc1;
    int n;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_D", D, 16'h0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    run_op(16'hAAAA, 16'h5555, 1'b0); drain();
    run_op(16'h0000, 16'h0003, 1'b0); drain();
    run_op(16'h0800, 16'hDAAA, 1'b1); drain();
    run_op(16'h0000, 16'h0000, 1'b1); drain();
    run_op(16'hFFFF, 16'hFFFF, 1'b0); drain();
    run_op(16'h8000, 16'h0001, 1'b0); drain();
    run_op(16'h7FFF, 16'hFFFF, 1'b0); drain();

    // Start pulsed mid-computation must be ignored.
    run_op(16'hAB32, 16'h2121, 1'b0);
    @(negedge clk);
    chk("ready_in_calc", ready, 1'b0);
    start = 1'b1; A = 16'hF800; B = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Back-to-back: start held through DONE accepts the second op there.
    wait_ready();
    start = 1'b1; A = 16'h1234; B = 16'h0FF0; bin = 1'b0;
    @(posedge clk);
    #1;
    acc1 = cyc;
    q.push_back(model(16'h1234, 16'h0FF0, 1'b0, acc1));
    q.push_back(model(16'hF800, 16'hFAAA, 1'b0, acc1 + 5));
    A = 16'hF800; B = 16'hFAAA;
    n = 0;
    while (cyc < acc1 + 5 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    A = 16'h0; B = 16'h0;
    drain();

    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom));
      drain();
    end

    // Reset in the second CALC cycle aborts with no done.
    run_op(16'h9000, 16'h1234, 1'b0);
    void'(q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready, 1'b1);
    chk("abort_D", D, 16'h0);
    chk("abort_bout", bout, 1'b0);
    chk("abort_ovf", ovf, 1'b0);
    repeat (8) @(negedge clk);

    run_op(16'h0005, 16'h0007, 1'b0); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 Parameter: W, 16, operand/result width; SHALL be a multiple of 4.
REQ-002 Parameter: SLICE, 4, bits processed per cycle; fixed at 4.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request; sampled only when ready=1.
REQ-006 Port: A  input  W  minuend, unsigned/two's-complement.
REQ-007 Port: B  input  W  subtrahend.
REQ-008 Port: bin  input  1  borrow-in.
REQ-009 Port: ready  output  1  high when a start will be accepted.
REQ-010 Port: done  output  1  one-cycle pulse; result valid.
REQ-011 Port: D  output  W  difference.
REQ-012 Port: bout  output  1  borrow-out.
REQ-013 Port: ovf  output  1  signed overflow.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, DONE.
REQ-015 Start accepted (start=1, ready=1) SHALL latch A, B, bin into internal registers, clear the slice index, and enter CALC.
REQ-016 ready SHALL be 1 in IDLE and DONE, 0 in CALC.
REQ-017 In CALC, each cycle SHALL subtract one 4-bit slice, LSB slice first, propagating the registered borrow to the next slice.
REQ-018 CALC SHALL last exactly W/4 cycles (4 for W=16); the slice index SHALL wrap 3->0 on CALC exit.
REQ-019 done SHALL be 1 for exactly the one cycle following the edge that completes the last slice (DONE state); start accepted at edge N gives done=1 in the cycle after edge N+4.
REQ-020 D, bout, ovf SHALL update only on CALC->DONE and SHALL hold until the next completion; intermediate slices SHALL NOT be visible on D.
REQ-021 D SHALL equal (A - B - bin) mod 2^W.
REQ-022 bout SHALL be 1 iff A < B + bin (unsigned).
REQ-023 ovf SHALL be 1 iff A[W-1] != B[W-1] and D[W-1] != A[W-1].
REQ-024 start while ready=0 SHALL be ignored, without corrupting the operation in progress.
REQ-025 start in the DONE cycle SHALL be accepted (back-to-back); the FSM goes DONE->CALC, otherwise DONE->IDLE.
REQ-026 Input changes on A/B/bin after acceptance SHALL NOT affect the result.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, ready=1, done=0, D=0, bout=0, ovf=0, slice index=0, and clear the latched operands.
REQ-028 rst SHALL take priority over start and abort a CALC in progress with no done pulse.

Structure
REQ-029 A shared package serial_sub_pkg SHALL hold W, SLICE, and the state enum.
REQ-030 One sub-module sub4 SHALL implement a combinational 4-bit slice: a, b, borrow-in to diff, borrow-out.
REQ-031 serial_sub16 SHALL instantiate exactly one sub4, time-multiplexed across slices.

Verification
REQ-032 A=AAAA, B=5555, bin=0 -> D=5555, bout=0, ovf=1, done exactly 4 edges after accept.
REQ-033 A=0000, B=0003, bin=0 -> D=FFFD, bout=1, ovf=0.
REQ-034 A=0800, B=DAAA, bin=1 -> D=2D55, bout=1, ovf=0.
REQ-035 Accept A=AB32, B=2121, then pulse start with A=F800 mid-CALC -> ignored; D=8A11, bout=0, ovf=0.
REQ-036 Back-to-back: start held through DONE with A=F800, B=FAAA -> second done 5 cycles after first; D=FD56, bout=1, ovf=0.
REQ-037 rst asserted in the 2nd CALC cycle -> next cycle IDLE, ready=1, D=0, bout=0, ovf=0; no done pulse follows.
